// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: frame geometry, address map and the
// frame-master state encoding.
package spi_pkg;

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned ADDR_MSB     = 15;
    localparam int unsigned ADDR_LSB     = 12;
    localparam logic [3:0]  ADDR_PWM_MAX = 4'h7;
    localparam logic [3:0]  ADDR_CLKDIV  = 4'h8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI serial clock generator: half-period counter producing an idle-low sck
// plus one-cycle rise/fall strobes that coincide with the registered sck edge.
module spi_sck_gen #(
    parameter int unsigned SCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          sck_q;
    logic          term;

    assign term = (cnt_q == CW'(SCK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (term) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Strobes are high in the cycle before the clk edge that flips sck.
    assign rise = en && term && !sck_q;
    assign fall = en && term &&  sck_q;
    assign sck  = sck_q;

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: serialises FRAME_BITS-bit command frames MSB first
// and captures miso on the same sck edges for loopback/readback.
module spi_frame_master #(
    parameter int unsigned FRAME_BITS = spi_pkg::FRAME_BITS,
    parameter int unsigned SCK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    import spi_pkg::*;

    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam int unsigned PW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q;
    logic                  sck_rise, sck_fall;

    spi_sck_gen #(
        .SCK_DIV(SCK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == SHIFT),
        .sck  (spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // mosi is the MSB of the transmit shifter; clearing the shifter idles mosi low.
    always_comb begin
        state_d    = state_q;
        ph_d       = '0;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_shift_d = tx_data;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (ph_q == PW'(CS_SETUP - 1)) state_d = SHIFT;
                else                           ph_d    = ph_q + 1'b1;
            end
            SHIFT: begin
                if (sck_rise) rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], miso_q};
                if (sck_fall) begin
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            HOLD: begin
                if (ph_q == PW'(CS_HOLD - 1)) begin
                    cs_n_d     = 1'b1;
                    tx_shift_d = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            GAP: begin
                if (ph_q == PW'(CS_GAP - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            ph_d  = '0;
            bit_d = '0;
        end
        tx_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= spi_miso;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = tx_shift_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: SPI slave/PWM-register model, table of frames
// (fixed and random) and hand-written multi-cycle corner cases.
module tb_spi_frame_master;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready, busy, rx_valid;
    logic [15:0] rx_data;
    logic        spi_cs_n, spi_sck, spi_mosi, spi_miso;

    logic        loopback = 1'b0;
    logic        slave_miso = 1'b0;
    logic [15:0] resp_next = '0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    assign spi_miso = loopback ? spi_mosi : slave_miso;

    spi_frame_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .spi_cs_n(spi_cs_n),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    // Slave and PWM-top register model: samples mosi on sck rise, drives miso on
    // cs fall / sck fall, decodes only complete 16-bit frames.
    int unsigned s_bits = 0;
    int unsigned s_rises_last = 0;
    logic [15:0] s_word = '0;
    logic [15:0] s_out  = '0;
    logic [15:0] slave_q[$];
    logic [11:0] pwm_cmp[8];
    logic [11:0] clkdiv = '0;

    always @(negedge spi_cs_n) begin
        s_bits = 0;
        s_word = '0;
        s_out  = resp_next;
        slave_miso = s_out[15];
    end

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            s_word = {s_word[14:0], spi_mosi};
            s_bits++;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n) begin
            s_out = s_out << 1;
            slave_miso = s_out[15];
        end
    end

    always @(posedge spi_cs_n) begin
        if (s_bits == 16) begin
            slave_q.push_back(s_word);
            s_rises_last = s_bits;
            if (s_word[ADDR_MSB:ADDR_LSB] <= ADDR_PWM_MAX)
                pwm_cmp[s_word[ADDR_LSB+2:ADDR_LSB]] = s_word[11:0];
            else if (s_word[ADDR_MSB:ADDR_LSB] == ADDR_CLKDIV)
                clkdiv = s_word[11:0];
        end
        s_bits = 0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called just after a negedge; returns at a negedge with the master idle again.
    task automatic run_frame(input logic [15:0] data, input logic [15:0] resp,
                             input logic loop, input logic disturb);
        int unsigned cyc, cs_low, rv_cnt, ready_wait;
        logic accepted, done, busy_ok;
        logic [15:0] exp_rx;
        exp_rx    = loop ? data : resp;
        loopback  = loop;
        resp_next = resp;
        tx_data   = data;
        tx_valid  = 1'b1;
        accepted  = 1'b0;
        cyc = 0;
        while (!accepted && cyc < 50) begin
            accepted = tx_ready;
            @(negedge clk);
            cyc++;
        end
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
        if (!accepted) begin
            check("accept_timeout", 0, 1);
            return;
        end
        check("mosi_first_bit", spi_mosi, data[15]);
        cs_low = 0; rv_cnt = 0; done = 1'b0; busy_ok = 1'b1; cyc = 0;
        while (!done && cyc < 400) begin
            if (!spi_cs_n) begin
                cs_low++;
                if (!busy) busy_ok = 1'b0;
                if (rx_valid) rv_cnt++;
                if (disturb && cs_low == 40) begin
                    tx_data  = ~data;
                    tx_valid = 1'b1;
                end else if (disturb && cs_low == 41) begin
                    tx_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check("frame_timeout", 0, 1);
            return;
        end
        check("cs_low_cycles", cs_low, 132);
        check("busy_in_frame", busy_ok, 1);
        check("rx_valid_at_cs_rise", rx_valid, 1);
        check("rx_data", rx_data, exp_rx);
        check("sck_idle_low", spi_sck, 0);
        check("mosi_idle_low", spi_mosi, 0);
        ready_wait = 0;
        while (!tx_ready && ready_wait < 20) begin
            @(negedge clk);
            ready_wait++;
            if (rx_valid) rv_cnt++;
        end
        check("ready_latency", ready_wait, 2);
        check("rx_valid_pulses", rv_cnt, 0);
        check("slave_frames", slave_q.size(), 1);
        if (slave_q.size() != 0) check("slave_decode", slave_q.pop_front(), data);
        check("sck_rises", s_rises_last, 16);
    endtask

    typedef struct {
        logic [15:0] tx;
        logic [15:0] resp;
        logic        loop;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int unsigned acc, hi_run, gap, cnt;
        logic seen_low;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", tx_ready, 1);

        vecs[0] = '{16'h8003, 16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'hA5C3, 16'h0000, 1'b1, 16'hA5C3};
        vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
        vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF};
        for (int i = 4; i < 10; i++) begin
            vecs[i].tx     = 16'($urandom);
            vecs[i].resp   = 16'($urandom);
            vecs[i].loop   = 1'($urandom_range(1));
            vecs[i].exp_rx = vecs[i].loop ? vecs[i].tx : vecs[i].resp;
        end
        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].tx, vecs[i].resp, vecs[i].loop, 1'b0);
            check("table_rx", rx_data, vecs[i].exp_rx);
        end
        check("clkdiv_8003", clkdiv, 12'h003);

        // Back-to-back frames with tx_valid held high.
        loopback = 1'b0;
        tx_data = 16'h1111; tx_valid = 1'b1;
        acc = 0; hi_run = 0; gap = 0; seen_low = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (tx_ready && tx_valid) acc++;
            @(negedge clk);
            if (acc == 1) tx_data = 16'h2222;
            if (acc == 2) tx_valid = 1'b0;
            if (spi_cs_n) begin
                if (seen_low) hi_run++;
            end else begin
                if (seen_low && hi_run != 0 && gap == 0) gap = hi_run;
                seen_low = 1'b1;
                hi_run = 0;
            end
            if (acc == 2 && spi_cs_n && tx_ready) break;
        end
        tx_valid = 1'b0;
        check("b2b_accepts", acc, 2);
        check("b2b_gap", gap, 3);
        check("b2b_frames", slave_q.size(), 2);
        if (slave_q.size() == 2) begin
            check("b2b_first", slave_q.pop_front(), 16'h1111);
            check("b2b_second", slave_q.pop_front(), 16'h2222);
        end
        slave_q.delete();

        // Reset after the 7th sck rise.
        loopback = 1'b1;
        tx_data = 16'hC3C3; tx_valid = 1'b1;
        cnt = 0;
        while (!tx_ready && cnt < 50) begin @(negedge clk); cnt++; end
        @(negedge clk);
        tx_valid = 1'b0;
        cnt = 0;
        while (s_bits < 7 && cnt < 200) begin @(negedge clk); cnt++; end
        check("abort_reached_7", s_bits, 7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_sck", spi_sck, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_tx_ready", tx_ready, 0);
        check("abort_rx_data", rx_data, 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (rx_valid || !spi_cs_n) cnt++;
            @(negedge clk);
        end
        check("abort_quiet", cnt, 0);
        check("abort_no_frame", slave_q.size(), 0);
        run_frame(16'h0FFF, 16'h0000, 1'b1, 1'b0);

        // Mid-frame tx_data change and extra request.
        run_frame(16'h5A5A, 16'h6C6C, 1'b0, 1'b1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (!spi_cs_n) cnt++;
            @(negedge clk);
        end
        check("no_extra_frame", cnt, 0);

        // PWM top end-to-end.
        run_frame(16'h3200, 16'($urandom), 1'b0, 1'b0);
        run_frame(16'h8002, 16'($urandom), 1'b0, 1'b0);
        check("pwm_ch3", pwm_cmp[3], 12'h200);
        check("clkdiv_2", clkdiv, 12'h002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
